// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the 8 x 8-bit register file: sequenced init (reg k <= k),
// then fixed-priority writeback/debug sharing with a debug starvation guard.
module regfile_write_ctrl #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int NUM_REGS     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              soft_init,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_gnt,
  output logic              wb_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              init_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_reg_num,
  output logic [DATA_W-1:0] Write_data
);

  localparam int SW = 4;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              busy_d, we_d;
  wr_t               wr_d;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      starve_q      <= '0;
      init_busy     <= 1'b1;
      RegWrite      <= 1'b0;
      Write_reg_num <= '0;
      Write_data    <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      starve_q      <= starve_d;
      init_busy     <= busy_d;
      RegWrite      <= we_d;
      Write_reg_num <= wr_d.addr;
      Write_data    <= wr_d.data;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    starve_d   = starve_q;
    busy_d     = init_busy;
    we_d       = 1'b0;
    wr_d       = '{addr: Write_reg_num, data: Write_data};
    wb_gnt     = 1'b0;
    dbg_gnt    = 1'b0;
    case (state_q)
      INIT: begin
        we_d       = 1'b1;
        wr_d       = '{addr: init_cnt_q, data: {{(DATA_W-ADDR_W){1'b0}}, init_cnt_q}};
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(NUM_REGS-1)) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (soft_init) begin
          // Restart takes the whole cycle: no grant, strobe drops, writes resume next edge.
          state_d    = INIT;
          init_cnt_d = '0;
          busy_d     = 1'b1;
          starve_d   = '0;
        end else begin
          dbg_gnt = dbg_req && (!wb_req || starve_q >= SW'(STARVE_LIMIT));
          wb_gnt  = wb_req && !dbg_gnt;
          if (dbg_gnt) begin
            we_d = 1'b1;
            wr_d = '{addr: dbg_addr, data: dbg_data};
          end else if (wb_gnt) begin
            we_d = 1'b1;
            wr_d = '{addr: wb_addr, data: wb_data};
          end
          if (dbg_gnt || !dbg_req)            starve_d = '0;
          else if (starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign wb_stall = wb_req && !wb_gnt;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: init sequence, arbitration, soft_init, async reset.
module tb_regfile_write_ctrl;
  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       soft_init = 1'b0;
  logic       wb_req = 1'b0, dbg_req = 1'b0;
  logic [2:0] wb_addr = '0, dbg_addr = '0;
  logic [7:0] wb_data = '0, dbg_data = '0;
  logic       wb_gnt, wb_stall, dbg_gnt, init_busy, RegWrite;
  logic [2:0] Write_reg_num;
  logic [7:0] Write_data;

  int n_chk = 0;
  int n_fail = 0;

  regfile_write_ctrl dut (
    .clk(clk), .Reset(Reset), .soft_init(soft_init),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_gnt(wb_gnt), .wb_stall(wb_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_gnt(dbg_gnt), .init_busy(init_busy), .RegWrite(RegWrite),
    .Write_reg_num(Write_reg_num), .Write_data(Write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [2:0] num, input logic [7:0] data);
    chk({tag, ".we"}, RegWrite, we);
    chk({tag, ".num"}, Write_reg_num, num);
    chk({tag, ".data"}, Write_data, data);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_wr("rst", 1'b0, 3'd0, 8'd0);
    chk("rst.busy", init_busy, 1);

    // Release reset with both requesters active: INIT must grant nothing.
    Reset = 1'b0; wb_req = 1'b1; dbg_req = 1'b1;
    #1;
    chk("init.wb_gnt", wb_gnt, 0);
    chk("init.dbg_gnt", dbg_gnt, 0);
    chk("init.stall", wb_stall, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_wr($sformatf("init%0d", k), 1'b1, 3'(k), 8'(k));
      chk($sformatf("init%0d.busy", k), init_busy, (k == 7) ? 0 : 1);
      if (k < 7) begin
        chk($sformatf("init%0d.wb_gnt", k), wb_gnt, 0);
        chk($sformatf("init%0d.dbg_gnt", k), dbg_gnt, 0);
      end
    end
    wb_req = 1'b0; dbg_req = 1'b0;

    // Single writeback.
    wb_req = 1'b1; wb_addr = 3'd3; wb_data = 8'hA5;
    #1;
    chk("wb.gnt", wb_gnt, 1);
    chk("wb.stall", wb_stall, 0);
    @(negedge clk);
    chk_wr("wb.strobe", 1'b1, 3'd3, 8'hA5);
    wb_req = 1'b0;
    @(negedge clk);
    chk_wr("wb.idle", 1'b0, 3'd3, 8'hA5);

    // Contention: debug wins after STARVE_LIMIT lost cycles.
    wb_req = 1'b1; wb_addr = 3'd1; wb_data = 8'h11;
    dbg_req = 1'b1; dbg_addr = 3'd5; dbg_data = 8'h3C;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("arb%0d.wb_gnt", c), wb_gnt, (c != 4) ? 1 : 0);
      chk($sformatf("arb%0d.dbg_gnt", c), dbg_gnt, (c == 4) ? 1 : 0);
      chk($sformatf("arb%0d.stall", c), wb_stall, (c == 4) ? 1 : 0);
      if (c > 0)
        chk_wr($sformatf("arb%0d.strobe", c), 1'b1, (c == 5) ? 3'd5 : 3'd1,
               (c == 5) ? 8'h3C : 8'h11);
      @(negedge clk);
    end
    wb_req = 1'b0; dbg_req = 1'b0;
    chk_wr("arb6.strobe", 1'b1, 3'd1, 8'h11);

    // Idle: strobe low, address/data hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_wr($sformatf("idle%0d", i), 1'b0, 3'd1, 8'h11);
    end

    // soft_init while writeback is requesting.
    soft_init = 1'b1; wb_req = 1'b1; wb_addr = 3'd2; wb_data = 8'h22;
    #1;
    chk("si.wb_gnt", wb_gnt, 0);
    chk("si.stall", wb_stall, 1);
    @(negedge clk);
    soft_init = 1'b0;
    #1;
    chk("si.we", RegWrite, 0);
    chk("si.busy", init_busy, 1);
    chk("si.wb_gnt_init", wb_gnt, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_wr($sformatf("si%0d", k), 1'b1, 3'(k), 8'(k));
    end
    #1;
    chk("si.resume", wb_gnt, 1);
    @(negedge clk);
    chk_wr("si.wb_strobe", 1'b1, 3'd2, 8'h22);
    wb_req = 1'b0;

    // Async reset in the middle of init.
    soft_init = 1'b1;
    @(negedge clk);
    soft_init = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_wr($sformatf("pre%0d", k), 1'b1, 3'(k), 8'(k));
    end
    #1 Reset = 1'b1;
    #1;
    chk_wr("arst", 1'b0, 3'd0, 8'd0);
    chk("arst.busy", init_busy, 1);
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_wr($sformatf("re%0d", k), 1'b1, 3'(k), 8'(k));
    end
    @(negedge clk);
    chk("re.end", RegWrite, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
